// File: rtl/wb_regfile_if.sv
// ----------------------------------------------------------------------------
// wb_regfile_if
//   Bundles the MEM/WB -> write-back signals with the ID-stage read ports and
//   the forwarding/perf outputs of the write-back register file.
//
//   Parameters
//     DATA_W  register/data width in bits
//     ADDR_W  register index width (2**ADDR_W registers)
//     CNT_W   width of the commit counter wbCount
//
//   Signals (direction as seen by the register file, modport slave)
//     WB_EN       in   write-back enable from the MEM/WB register
//     MEM_R_EN    in   1: write back memReadVal, 0: write back ALURes
//     dest        in   destination register index
//     ALURes      in   ALU result
//     memReadVal  in   load data
//     src1, src2  in   read port indices (ID stage)
//     reg1, reg2  out  read port data
//     wbValue     out  selected write-back value (forwarding unit)
//     wbCount     out  committed writes since reset
//
//   Modports: slave = register file, master = pipeline / testbench driver.
// ----------------------------------------------------------------------------
interface wb_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
);
    logic              WB_EN;
    logic              MEM_R_EN;
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] ALURes;
    logic [DATA_W-1:0] memReadVal;
    logic [ADDR_W-1:0] src1;
    logic [ADDR_W-1:0] src2;
    logic [DATA_W-1:0] reg1;
    logic [DATA_W-1:0] reg2;
    logic [DATA_W-1:0] wbValue;
    logic [CNT_W-1:0]  wbCount;

    modport slave (
        input  WB_EN, MEM_R_EN, dest, ALURes, memReadVal, src1, src2,
        output reg1, reg2, wbValue, wbCount
    );

    modport master (
        output WB_EN, MEM_R_EN, dest, ALURes, memReadVal, src1, src2,
        input  reg1, reg2, wbValue, wbCount
    );
endinterface

// File: rtl/wb_regfile.sv
// ----------------------------------------------------------------------------
// wb_regfile
//   Write-back stage and architectural register file. Selects the write-back
//   value (load data or ALU result), commits it to the register file, provides
//   two combinational read ports to the ID stage, exports the selected value
//   to the forwarding unit and counts committed write-backs.
//
//   Register 0 is hardwired to zero: writes to it are dropped (and not
//   counted), reads of it return zero.
//
//   Ports
//     clk   in  rising-edge clock
//     rstn  in  asynchronous active-low reset; clears all registers and the
//               commit counter immediately and blocks commits while low
//     bus   wb_regfile_if.slave (see rtl/wb_regfile_if.sv for the signals)
//
//   Build option
//     RF_BYPASS_EN  when defined, a read whose index matches the register
//                   being committed this cycle returns wbValue in the same
//                   cycle (write-through). When undefined, reads always show
//                   the stored value. Register state and wbCount are identical
//                   in both builds.
// ----------------------------------------------------------------------------
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic         clk,
    input  logic         rstn,
    wb_regfile_if.slave  bus
);

    localparam int unsigned NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREGS];
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] wb_value;
    logic              commit;

    // Write-back value selection; independent of WB_EN and of reset.
    always_comb begin
        wb_value = bus.MEM_R_EN ? bus.memReadVal : bus.ALURes;
    end

    // Gating with rstn keeps the same-cycle bypass from leaking a value onto
    // the read ports while the file is held in reset.
    always_comb begin
        commit = bus.WB_EN && (bus.dest != '0) && rstn;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            cnt_q <= '0;
        end else if (commit) begin
            regs[bus.dest] <= wb_value;
            cnt_q          <= cnt_q + CNT_W'(1);
        end
    end

    // Read ports. Index 0 yields zero without relying on regs[0]; since commit
    // is never set for dest 0, the bypass can never override that.
    always_comb begin
        bus.reg1 = (bus.src1 == '0) ? '0 : regs[bus.src1];
        bus.reg2 = (bus.src2 == '0) ? '0 : regs[bus.src2];
`ifdef RF_BYPASS_EN
        if (commit && (bus.src1 == bus.dest)) begin
            bus.reg1 = wb_value;
        end
        if (commit && (bus.src2 == bus.dest)) begin
            bus.reg2 = wb_value;
        end
`endif
    end

    always_comb begin
        bus.wbValue = wb_value;
        bus.wbCount = cnt_q;
    end

endmodule

// File: tb/tb_wb_regfile.sv
// ----------------------------------------------------------------------------
// tb_wb_regfile
//   Directed-vector bench for wb_regfile. u_dut uses the default widths;
//   u_wrap uses a 4-bit commit counter to exercise the wrap-around.
//   Expected values are hand-computed constants.
// ----------------------------------------------------------------------------
module tb_wb_regfile;

    logic clk;
    logic rstn;

    int unsigned n_vec;
    int unsigned n_bad;

    wb_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) bus ();
    wb_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  bus_w ();

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) u_wrap (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_w.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic mr, input logic [4:0] d,
                         input logic [31:0] alu, input logic [31:0] mem);
        bus.WB_EN      = we;
        bus.MEM_R_EN   = mr;
        bus.dest       = d;
        bus.ALURes     = alu;
        bus.memReadVal = mem;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rstn  = 1'b0;
        drive(1'b0, 1'b0, 5'd0, '0, '0);
        bus.src1 = 5'd0;
        bus.src2 = 5'd0;
        bus_w.WB_EN      = 1'b0;
        bus_w.MEM_R_EN   = 1'b0;
        bus_w.dest       = 5'd0;
        bus_w.ALURes     = '0;
        bus_w.memReadVal = '0;
        bus_w.src1       = 5'd1;
        bus_w.src2       = 5'd0;

        // Power-on reset state
        #3;
        bus.src1 = 5'd5;
        bus.src2 = 5'd7;
        #1;
        check("rst_reg1", bus.reg1, 32'h0);
        check("rst_reg2", bus.reg2, 32'h0);
        check("rst_cnt", bus.wbCount, 32'h0);
        tick();
        rstn = 1'b1;

        // ALU write to r5
        drive(1'b1, 1'b0, 5'd5, 32'hDEAD_BEEF, 32'h0BAD_0BAD);
        #1;
        check("alu_wbval", bus.wbValue, 32'hDEAD_BEEF);
        tick();
        bus.WB_EN = 1'b0;
        bus.src1  = 5'd5;
        #1;
        check("alu_reg1", bus.reg1, 32'hDEAD_BEEF);
        check("alu_cnt", bus.wbCount, 32'd1);

        // Load write to r7
        drive(1'b1, 1'b1, 5'd7, 32'hFFFF_FFFF, 32'h1234_5678);
        #1;
        check("ld_wbval", bus.wbValue, 32'h1234_5678);
        tick();
        bus.WB_EN = 1'b0;
        bus.src2  = 5'd7;
        #1;
        check("ld_reg2", bus.reg2, 32'h1234_5678);
        check("ld_cnt", bus.wbCount, 32'd2);

        // Write to r0 is dropped and not counted
        drive(1'b1, 1'b0, 5'd0, 32'hAAAA_AAAA, 32'h0);
        tick();
        bus.WB_EN = 1'b0;
        bus.src1  = 5'd0;
        #1;
        check("r0_reg1", bus.reg1, 32'h0);
        check("r0_cnt", bus.wbCount, 32'd2);

        // WB_EN low: no write, but wbValue still follows inputs
        drive(1'b0, 1'b0, 5'd3, 32'h5555_5555, 32'h0);
        #1;
        check("noen_wbval", bus.wbValue, 32'h5555_5555);
        tick();
        bus.src1 = 5'd3;
        #1;
        check("noen_reg1", bus.reg1, 32'h0);
        check("noen_cnt", bus.wbCount, 32'd2);

        // Highest index
        drive(1'b1, 1'b0, 5'd31, 32'h3131_3131, 32'h0);
        tick();
        bus.WB_EN = 1'b0;
        bus.src1  = 5'd31;
        bus.src2  = 5'd5;
        #1;
        check("r31_reg1", bus.reg1, 32'h3131_3131);
        check("r31_reg2_r5", bus.reg2, 32'hDEAD_BEEF);
        check("r31_cnt", bus.wbCount, 32'd3);

        // Both ports on the same index
        bus.src1 = 5'd7;
        bus.src2 = 5'd7;
        #1;
        check("same_reg1", bus.reg1, 32'h1234_5678);
        check("same_reg2", bus.reg2, 32'h1234_5678);

        // Same-cycle write/read of r9
        drive(1'b1, 1'b0, 5'd9, 32'd1, 32'h0);
        tick();
        drive(1'b1, 1'b0, 5'd9, 32'd2, 32'h0);
        bus.src1 = 5'd9;
        bus.src2 = 5'd9;
        #1;
`ifdef RF_BYPASS_EN
        check("byp_reg1_pre", bus.reg1, 32'd2);
        check("byp_reg2_pre", bus.reg2, 32'd2);
`else
        check("byp_reg1_pre", bus.reg1, 32'd1);
        check("byp_reg2_pre", bus.reg2, 32'd1);
`endif
        tick();
        bus.WB_EN = 1'b0;
        #1;
        check("byp_reg1_post", bus.reg1, 32'd2);
        check("byp_reg2_post", bus.reg2, 32'd2);
        check("byp_cnt", bus.wbCount, 32'd5);

        // Asynchronous reset between edges
        bus.src1 = 5'd5;
        bus.src2 = 5'd7;
        #1;
        rstn = 1'b0;
        #1;
        check("arst_reg1", bus.reg1, 32'h0);
        check("arst_reg2", bus.reg2, 32'h0);
        check("arst_cnt", bus.wbCount, 32'h0);
        drive(1'b1, 1'b1, 5'd5, 32'h0, 32'hCAFE_F00D);
        #1;
        check("arst_wbval", bus.wbValue, 32'hCAFE_F00D);
        check("arst_nobyp", bus.reg1, 32'h0);
        tick();
        check("arst_nowr", bus.reg1, 32'h0);
        check("arst_nocnt", bus.wbCount, 32'h0);

        // Release, then commit on the very first edge with rstn high
        drive(1'b1, 1'b0, 5'd5, 32'h0000_0077, 32'h0);
        #2;
        rstn = 1'b1;
        tick();
        bus.WB_EN = 1'b0;
        #1;
        check("rel_reg1", bus.reg1, 32'h0000_0077);
        check("rel_cnt", bus.wbCount, 32'd1);

        // 4-bit counter wrap on u_wrap: 17 commits to r1
        for (int i = 0; i < 17; i++) begin
            bus_w.WB_EN  = 1'b1;
            bus_w.dest   = 5'd1;
            bus_w.ALURes = 32'h100 + 32'(i);
            tick();
            check($sformatf("wrap_cnt_%0d", i + 1), 32'(bus_w.wbCount), 32'((i + 1) % 16));
        end
        bus_w.WB_EN = 1'b0;
        #1;
        check("wrap_reg1", bus_w.reg1, 32'h110);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
